// File: rtl/spi_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_mem_bridge: mode-0 SPI slave bridge to a DEPTH-byte config memory   |
// |   with NUM_FLAGS sticky flags. Optional SPI_AUTOINC_EN: burst addr incr. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_mem_bridge #(
    parameter int DEPTH     = 115,
    parameter int NUM_FLAGS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 ss_n,
    output logic                 miso,
    output logic [DEPTH*8-1:0]   all_data_out,
    output logic [NUM_FLAGS-1:0] flags_out,
    output logic                 byte_valid,
    output logic                 instr_done,
    output logic                 err
);
    localparam int          c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] c_DEPTH = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_INSTR, S_ADDR_H, S_ADDR_L, S_WRITE, S_READ, S_IGNORE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_sclk_s;
    logic [1:0]            r_mosi_s;
    logic [2:0]            r_ss_s;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_shift;
    logic [7:0]            r_rx;
    logic                  r_byte_done;
    logic [15:0]           r_addr;
    logic [7:0]            r_tx;
    logic                  r_is_write;
    logic                  r_did;
    logic [NUM_FLAGS-1:0]  r_flags;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_ss_n;
    logic                  w_ss_fall;
    logic                  w_ss_rise;
    logic [15:0]           w_cur_addr;
    logic [15:0]           w_next_addr;
    logic                  w_in_range;
    logic [7:0]            w_mem_rd;
    logic                  w_flag_ok;
    logic [NUM_FLAGS-1:0]  w_flag_mask;

    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
    assign w_ss_n      = r_ss_s[1];
    assign w_ss_fall   = ~r_ss_s[1] & r_ss_s[2];
    assign w_ss_rise   = r_ss_s[1] & ~r_ss_s[2];

    // The low address byte is still in r_rx when ADDR_L completes.
    assign w_cur_addr  = (r_state == S_ADDR_L) ? {r_addr[15:8], r_rx} : r_addr;
    assign w_in_range  = ({1'b0, w_cur_addr} < c_DEPTH);
    assign w_mem_rd    = w_in_range ? r_mem[w_cur_addr[c_AW-1:0]] : 8'h00;
`ifdef SPI_AUTOINC_EN
    assign w_next_addr = w_cur_addr + 16'd1;
`else
    assign w_next_addr = w_cur_addr;
`endif
    assign w_flag_ok   = ({1'b0, r_rx[3:0]} < 5'(NUM_FLAGS));
    assign w_flag_mask = NUM_FLAGS'(1) << r_rx[3:0];
    assign flags_out   = r_flags;

    // Select synchroniser resets low so a reset in mid-frame never fakes a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_s    <= '0;
            r_mosi_s    <= '0;
            r_ss_s      <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx        <= '0;
            r_byte_done <= 1'b0;
        end else begin
            r_sclk_s    <= {r_sclk_s[1:0], sclk};
            r_mosi_s    <= {r_mosi_s[0], mosi};
            r_ss_s      <= {r_ss_s[1:0], ss_n};
            r_byte_done <= 1'b0;
            if (w_ss_n || r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_shift[5:0], r_mosi_s[1]};
                if (r_bit_cnt == 3'd7) begin
                    r_rx        <= {r_shift, r_mosi_s[1]};
                    r_byte_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_tx       <= '0;
            r_is_write <= 1'b0;
            r_did      <= 1'b0;
            r_flags    <= '0;
            miso       <= 1'b0;
            byte_valid <= 1'b0;
            instr_done <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            byte_valid <= 1'b0;
            instr_done <= 1'b0;
            err        <= 1'b0;
            if (w_ss_rise) begin
                r_state    <= S_IDLE;
                instr_done <= r_did;
                r_did      <= 1'b0;
                miso       <= 1'b0;
            end else if (r_state == S_IDLE) begin
                miso <= 1'b0;
                if (w_ss_fall) begin
                    r_state <= S_INSTR;
                    r_did   <= 1'b0;
                end
            end else begin
                if (r_state == S_READ && w_sclk_fall) begin
                    miso <= r_tx[7];
                    r_tx <= {r_tx[6:0], 1'b0};
                end else if (r_state != S_READ) begin
                    miso <= 1'b0;
                end
                if (r_byte_done) begin
                    byte_valid <= 1'b1;
                    case (r_state)
                        S_INSTR: begin
                            if (r_rx == 8'h01 || r_rx == 8'h02) begin
                                r_is_write <= (r_rx == 8'h01);
                                r_state    <= S_ADDR_H;
                            end else if (r_rx[7:4] == 4'h1 && w_flag_ok) begin
                                r_flags <= r_flags | w_flag_mask;
                                r_did   <= 1'b1;
                                r_state <= S_IGNORE;
                            end else if (r_rx[7:4] == 4'h2 && w_flag_ok) begin
                                r_flags <= r_flags & ~w_flag_mask;
                                r_did   <= 1'b1;
                                r_state <= S_IGNORE;
                            end else begin
                                err     <= 1'b1;
                                r_state <= S_IGNORE;
                            end
                        end
                        S_ADDR_H: begin
                            r_addr[15:8] <= r_rx;
                            r_state      <= S_ADDR_L;
                        end
                        S_ADDR_L: begin
                            if (r_is_write) begin
                                r_addr  <= w_cur_addr;
                                r_state <= S_WRITE;
                            end else begin
                                r_tx    <= w_mem_rd;
                                err     <= ~w_in_range;
                                r_addr  <= w_next_addr;
                                r_state <= S_READ;
                            end
                        end
                        S_WRITE: begin
                            if (w_in_range) r_mem[w_cur_addr[c_AW-1:0]] <= r_rx;
                            else            err <= 1'b1;
                            r_addr <= w_next_addr;
                            r_did  <= 1'b1;
                        end
                        S_READ: begin
                            r_tx   <= w_mem_rd;
                            err    <= ~w_in_range;
                            r_addr <= w_next_addr;
                            r_did  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            all_data_out <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) all_data_out[8*i +: 8] <= r_mem[i];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_mem_bridge: randomized SPI frames against a byte-level model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_mem_bridge;
    localparam int DEPTH = 115;
    localparam int NF    = 3;
    localparam int HALF  = 50;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sclk = 1'b0;
    logic               mosi = 1'b0;
    logic               ss_n = 1'b1;
    logic               miso;
    logic [DEPTH*8-1:0] all_data_out;
    logic [NF-1:0]      flags_out;
    logic               byte_valid;
    logic               instr_done;
    logic               err;

    spi_mem_bridge #(.DEPTH(DEPTH), .NUM_FLAGS(NF)) dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .all_data_out(all_data_out), .flags_out(flags_out),
        .byte_valid(byte_valid), .instr_done(instr_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_bv  = 0;
    int n_id  = 0;
    int n_err = 0;

    logic [7:0]    m_mem [DEPTH];
    logic [NF-1:0] m_flags;
    logic [7:0]    fq[$];
    logic [7:0]    rq[$];

    always @(negedge clk) begin
        if (byte_valid === 1'b1) n_bv++;
        if (instr_done === 1'b1) n_id++;
        if (err === 1'b1)        n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #HALF;
            rx[i] = miso;
            sclk  = 1'b1;
            #HALF;
            sclk  = 1'b0;
        end
    endtask

    task automatic check_state();
        chk("miso_idle", 32'(miso), 32'd0);
        chk("flags", 32'(flags_out), 32'(m_flags));
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("mem[%0d]", k), 32'(all_data_out[8*k +: 8]), 32'(m_mem[k]));
    endtask

    // Sends fq as one frame (plus extra_bits trailing bits) and checks it against the model.
    task automatic frame(input int extra_bits);
        int          c_bv, c_id, c_err, e_err, n;
        logic        e_done;
        logic [15:0] a;
        logic [7:0]  r, op, ev;
        c_bv = n_bv; c_id = n_id; c_err = n_err;
        rq.delete();
        ss_n = 1'b0;
        #HALF;
        foreach (fq[i]) begin
            spi_byte(fq[i], r);
            rq.push_back(r);
        end
        for (int j = 0; j < extra_bits; j++) begin
            mosi = 1'($urandom);
            #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        #HALF;
        ss_n = 1'b1;
        #(4*HALF);

        n = fq.size(); e_err = 0; e_done = 1'b0;
        if (n > 0) begin
            op = fq[0];
            if (op == 8'h01 || op == 8'h02) begin
                if (n >= 3) begin
                    a = {fq[1], fq[2]};
                    for (int i = 3; i < n; i++) begin
                        if (op == 8'h01) begin
                            if (int'(a) < DEPTH) m_mem[int'(a)] = fq[i];
                            else                 e_err++;
                        end else begin
                            ev = (int'(a) < DEPTH) ? m_mem[int'(a)] : 8'h00;
                            if (int'(a) >= DEPTH) e_err++;
                            chk("rd_data", 32'(rq[i]), 32'(ev));
                        end
                        e_done = 1'b1;
`ifdef SPI_AUTOINC_EN
                        a = a + 16'd1;
`endif
                    end
                end
            end else if (op[7:4] == 4'h1 && int'(op[3:0]) < NF) begin
                m_flags[int'(op[3:0])] = 1'b1;
                e_done = 1'b1;
            end else if (op[7:4] == 4'h2 && int'(op[3:0]) < NF) begin
                m_flags[int'(op[3:0])] = 1'b0;
                e_done = 1'b1;
            end else begin
                e_err = 1;
            end
        end
        chk("byte_valid_cnt", 32'(n_bv - c_bv), 32'(n));
        chk("err_cnt", 32'(n_err - c_err), 32'(e_err));
        chk("instr_done_cnt", 32'(n_id - c_id), 32'(e_done));
        check_state();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r;
        logic [15:0] a;
        int          kind, len, c_bv, c_id, c_err;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
        m_flags = '0;

        #20;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_mem_any", 32'(|all_data_out), 32'd0);
        chk("rst_flags", 32'(flags_out), 32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_instr_done", 32'(instr_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        #100;

        fq = '{8'h01, 8'h00, 8'h04, 8'hA5};
        frame(0);
        chk("single_write_byte4", 32'(all_data_out[39:32]), 32'hA5);

        fq = '{8'h01, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
        frame(0);
        fq = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        frame(0);

        fq = '{8'h11};
        frame(0);
        chk("set_flag1", 32'(flags_out), 32'b010);
        fq = '{8'h21};
        frame(0);
        chk("clr_flag1", 32'(flags_out), 32'b000);
        fq = '{8'h13};
        frame(0);

        fq = '{8'h01, 8'h00, 8'h72, 8'h5A};
        frame(0);
        fq = '{8'h01, 8'h00, 8'h73, 8'hC3};
        frame(0);

        fq = '{8'h01, 8'h00, 8'h10};
        frame(4);

        // Reset in the middle of a READ data byte.
        ss_n = 1'b0;
        #HALF;
        spi_byte(8'h02, r); spi_byte(8'h00, r); spi_byte(8'h05, r);
        for (int j = 0; j < 4; j++) begin
            #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        reset_n = 1'b0;
        #20;
        chk("midrst_miso", 32'(miso), 32'd0);
        chk("midrst_mem_any", 32'(|all_data_out), 32'd0);
        chk("midrst_flags", 32'(flags_out), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
        m_flags = '0;
        c_bv = n_bv; c_id = n_id; c_err = n_err;
        for (int j = 0; j < 4; j++) begin
            #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        spi_byte(8'h01, r); spi_byte(8'hFF, r);
        #HALF;
        ss_n = 1'b1;
        #(4*HALF);
        chk("midrst_byte_valid", 32'(n_bv - c_bv), 32'd0);
        chk("midrst_instr_done", 32'(n_id - c_id), 32'd0);
        chk("midrst_err", 32'(n_err - c_err), 32'd0);

        for (int t = 0; t < 30; t++) begin
            fq.delete();
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    a = 16'($urandom_range(0, DEPTH-1));
                    len = $urandom_range(0, 4);
                    fq.push_back(8'h01); fq.push_back(a[15:8]); fq.push_back(a[7:0]);
                    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
                end
                1: begin
                    a = ($urandom_range(0, 1) == 0) ? 16'(DEPTH - 2 + $urandom_range(0, 3)) : 16'hFFFE;
                    len = $urandom_range(1, 4);
                    fq.push_back(8'h01); fq.push_back(a[15:8]); fq.push_back(a[7:0]);
                    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
                end
                2: begin
                    a = 16'($urandom_range(0, DEPTH-8));
                    len = $urandom_range(1, 4);
                    fq.push_back(8'h02); fq.push_back(a[15:8]); fq.push_back(a[7:0]);
                    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
                end
                3: begin
                    fq.push_back((($urandom_range(0, 1) == 0) ? 8'h10 : 8'h20) + 8'($urandom_range(0, NF)));
                    len = $urandom_range(0, 2);
                    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
                end
                default: begin
                    r = 8'($urandom);
                    if (r == 8'h01 || r == 8'h02) r = 8'hFF;
                    fq.push_back(r);
                    len = $urandom_range(0, 3);
                    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
                end
            endcase
            frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
